// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code to ASCII decoder feeding a valid/ready character buffer.
// Define PS2_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  // Result is {mapped, ascii}; unmapped codes return all zeros.
  function automatic logic [8:0] map_code(input logic [7:0] code);
    logic [8:0] res;
    case (code)
      8'h1C: res = 9'h141;  8'h32: res = 9'h142;  8'h21: res = 9'h143;  8'h23: res = 9'h144;
      8'h24: res = 9'h145;  8'h2B: res = 9'h146;  8'h34: res = 9'h147;  8'h33: res = 9'h148;
      8'h43: res = 9'h149;  8'h3B: res = 9'h14A;  8'h42: res = 9'h14B;  8'h4B: res = 9'h14C;
      8'h3A: res = 9'h14D;  8'h31: res = 9'h14E;  8'h44: res = 9'h14F;  8'h4D: res = 9'h150;
      8'h15: res = 9'h151;  8'h2D: res = 9'h152;  8'h1B: res = 9'h153;  8'h2C: res = 9'h154;
      8'h3C: res = 9'h155;  8'h2A: res = 9'h156;  8'h1D: res = 9'h157;  8'h22: res = 9'h158;
      8'h35: res = 9'h159;  8'h1A: res = 9'h15A;
      8'h45: res = 9'h130;  8'h16: res = 9'h131;  8'h1E: res = 9'h132;  8'h26: res = 9'h133;
      8'h25: res = 9'h134;  8'h2E: res = 9'h135;  8'h36: res = 9'h136;  8'h3D: res = 9'h137;
      8'h3E: res = 9'h138;  8'h46: res = 9'h139;
      8'h29: res = 9'h120;  8'h5A: res = 9'h10D;  8'h49: res = 9'h12E;  8'h41: res = 9'h12C;
      8'h4A: res = 9'h12F;
      default: res = 9'h000;
    endcase
    return res;
  endfunction

  state_t     state_r, next_state_s;
  logic       push_s;
  logic [7:0] push_char_s;
  logic [8:0] lookup_s;
  logic [7:0] char_data_r;
  logic       char_valid_r;
  logic       overflow_r;
  logic       pop_s;

  // Prefix-tracking state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; only plain make codes seen from IDLE request a push.
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    push_char_s  = 8'h00;
    lookup_s     = map_code(ps2_received_data);
    if (ps2_received_data_strb) begin
      case (state_r)
        IDLE: begin
          if (ps2_received_data == 8'hF0) begin
            next_state_s = BRK;
          end else if (ps2_received_data == 8'hE0) begin
            next_state_s = EXT;
          end else begin
            next_state_s = IDLE;
            push_s       = lookup_s[8];
            push_char_s  = lookup_s[7:0];
          end
        end
        BRK:     next_state_s = IDLE;
        EXT: begin
          if (ps2_received_data == 8'hF0) begin
            next_state_s = EXT_BRK;
          end else begin
            next_state_s = IDLE;
          end
        end
        EXT_BRK: next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

`ifdef PS2_FIFO_EN
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic          full_s, push_ok_s;
  logic [7:0]    head_nxt_s;

  // FIFO control; the head is precomputed so char_data comes straight from a flop.
  always_comb begin
    pop_s        = char_valid_r && char_ready;
    full_s       = (count_r == DEPTH_C);
    push_ok_s    = push_s && (!full_s || pop_s);
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
      2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
    if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_char_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      char_data_r  <= 8'h00;
      char_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_char_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      char_data_r  <= head_nxt_s;
      char_valid_r <= (count_nxt_s != '0);
      overflow_r   <= push_s && full_s && !pop_s;
    end
  end
`else
  logic push_ok_s;

  // Single holding register: accepts a push when empty or being drained this cycle.
  always_comb begin
    pop_s     = char_valid_r && char_ready;
    push_ok_s = push_s && (!char_valid_r || pop_s);
  end

  // Holding register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_data_r  <= 8'h00;
      char_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        char_data_r  <= push_char_s;
        char_valid_r <= 1'b1;
      end else if (pop_s) begin
        char_valid_r <= 1'b0;
      end else begin
        char_valid_r <= char_valid_r;
      end
      overflow_r <= push_s && char_valid_r && !pop_s;
    end
  end
`endif

  assign char_data  = char_data_r;
  assign char_valid = char_valid_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with an expected-character scoreboard queue.
// Covers both buffer builds depending on whether PS2_FIFO_EN is defined.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       overflow;

  logic [7:0] exp_q [$];
  int         pass_cnt  = 0;
  int         check_cnt = 0;
  int         ovf_cnt   = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [15:0] map_tbl [41] = '{
    16'h1C41, 16'h3242, 16'h2143, 16'h2344, 16'h2445, 16'h2B46, 16'h3447, 16'h3348,
    16'h4349, 16'h3B4A, 16'h424B, 16'h4B4C, 16'h3A4D, 16'h314E, 16'h444F, 16'h4D50,
    16'h1551, 16'h2D52, 16'h1B53, 16'h2C54, 16'h3C55, 16'h2A56, 16'h1D57, 16'h2258,
    16'h3559, 16'h1A5A, 16'h4530, 16'h1631, 16'h1E32, 16'h2633, 16'h2534, 16'h2E35,
    16'h3636, 16'h3D37, 16'h3E38, 16'h4639, 16'h2920, 16'h5A0D, 16'h492E, 16'h412C,
    16'h4A2F
  };

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .char_data              (char_data),
    .char_valid             (char_valid),
    .char_ready             (char_ready),
    .overflow               (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    @(posedge clk); #1;
    ps2_received_data_strb = 1'b0;
    ps2_received_data      = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || char_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
    check({tag, "_valid"}, {31'd0, char_valid}, 32'd0);
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected character.
  always @(negedge clk) begin
    if (rst) begin
      if (overflow) ovf_cnt <= ovf_cnt + 1;
      if (prev_hold) check("hold_stable", {24'd0, char_data}, {24'd0, prev_data});
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) check("unexpected_char", {24'd0, char_data}, 32'h100);
        else check("char_data", {24'd0, char_data}, {24'd0, exp_q.pop_front()});
      end
      prev_hold <= char_valid && !char_ready;
      prev_data <= char_data;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  initial begin
    rst = 1'b0; ps2_received_data = 8'h00; ps2_received_data_strb = 1'b0; char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, char_valid}, 32'd0);
    check("rst_data", {24'd0, char_data}, 32'h00);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    idle(1);

    // First character: one-cycle latency, popped at the next edge.
    char_ready = 1'b1;
    exp_q.push_back(8'h41);
    send(8'h1C);
    check("first_valid", {31'd0, char_valid}, 32'd1);
    check("first_data", {24'd0, char_data}, 32'h41);
    idle(1);
    check("first_popped", {31'd0, char_valid}, 32'd0);
    check("first_queue", exp_q.size(), 32'd0);

    // Break and extended prefixes.
    exp_q.push_back(8'h45);
    send(8'h24); send(8'hF0); send(8'h24);
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    exp_q.push_back(8'h0D);
    send(8'h5A);
    wait_drain("prefix");

    // Prefix bytes swallowed by BRK / EXT / EXT_BRK, then typematic repeats.
    send(8'hF0); send(8'hF0); exp_q.push_back(8'h41); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'hE0); exp_q.push_back(8'h46); send(8'h2B);
    send(8'hE0); send(8'hE0); exp_q.push_back(8'h41); send(8'h1C);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h41);
      send(8'h1C);
    end
    wait_drain("prefix_swallow");

    // Unmapped bytes produce nothing.
    send(8'hAA); send(8'hFA); send(8'hEE); send(8'hFE); send(8'h00); send(8'hFF);
    idle(2);
    check("unmapped_valid", {31'd0, char_valid}, 32'd0);

    // Full map, back-to-back strobes.
    for (int i = 0; i < 41; i++) begin
      exp_q.push_back(map_tbl[i][7:0]);
      send(map_tbl[i][15:8]);
    end
    wait_drain("map_sweep");

    // Reset in the middle of a break sequence.
    send(8'hF0);
    rst = 1'b0;
    idle(2);
    check("midrst_valid", {31'd0, char_valid}, 32'd0);
    rst = 1'b1;
    idle(1);
    exp_q.push_back(8'h31);
    send(8'h16);
    send(8'hAA); send(8'hFA);
    wait_drain("midrst");

`ifdef PS2_FIFO_EN
    // Fill the FIFO with ready low; the fifth push overflows.
    char_ready = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send(8'h24);
    check("fifo_ovf_pulse", {31'd0, overflow}, 32'd1);
    idle(1);
    check("fifo_ovf_clear", {31'd0, overflow}, 32'd0);
    check("fifo_head", {24'd0, char_data}, 32'h41);
    // Push into a full FIFO while popping is accepted.
    char_ready = 1'b1;
    exp_q.push_back(8'h30);
    send(8'h45);
    check("fifo_pushpop_ovf", {31'd0, overflow}, 32'd0);
    wait_drain("fifo_drain");
`else
    // Holding register full with ready low: the second byte overflows.
    char_ready = 1'b0;
    exp_q.push_back(8'h41);
    send(8'h1C);
    send(8'h32);
    check("reg_ovf_pulse", {31'd0, overflow}, 32'd1);
    check("reg_held", {24'd0, char_data}, 32'h41);
    idle(1);
    check("reg_ovf_clear", {31'd0, overflow}, 32'd0);
    check("reg_valid", {31'd0, char_valid}, 32'd1);
    char_ready = 1'b1;
    wait_drain("reg_drain");
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    send(8'h1C); send(8'h32);
    wait_drain("reg_b2b");
`endif

    check("ovf_total", ovf_cnt, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw PS/2 Set-2 byte stream from the PS/2 receive stage into ASCII characters for the Morse encoder. It consumes `ps2_received_data` / `ps2_received_data_strb` and tracks break (F0) and extended (E0) prefixes so that only key presses are emitted. Mapped make codes are queued in a small output buffer. The Morse encoder drains the buffer over a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output buffer entries; power of two, 2..16. Used only with `PS2_FIFO_EN`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `ps2_received_data`  in  8  received scan-code byte; valid only while the strobe is high.
- `ps2_received_data_strb`  in  1  one-cycle pulse per received byte.
- `char_data`  out  8  ASCII character at the head of the buffer.
- `char_valid`  out  1  buffer is non-empty.
- `char_ready`  in  1  consumer accepts `char_data` when `char_valid && char_ready`.
- `overflow`  out  1  one-cycle pulse when a mapped character is dropped because the buffer is full.

## Operation
- Decoder FSM advances only on `ps2_received_data_strb`. Its states are IDLE, BRK, EXT and EXT_BRK.
- IDLE transitions:
  - Byte F0 → BRK.
  - Byte E0 → EXT.
  - Any other byte is looked up in the map. A mapped byte is pushed; an unmapped byte is ignored. Stay in IDLE.
- BRK: any byte (including F0 or E0) is discarded → IDLE.
- EXT transitions:
  - Byte F0 → EXT_BRK.
  - Any other byte is discarded → IDLE. Extended keys are never emitted.
- EXT_BRK: any byte is discarded → IDLE.
- Map (Set-2 code → ASCII):
  - Letters: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A. Letters are always uppercase, 0x41–0x5A.
  - Digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46 → 0x30–0x39.
  - Punctuation and control: space 29 → 0x20, enter 5A → 0x0D, period 49 → 0x2E, comma 41 → 0x2C, slash 4A → 0x2F.
  - Every other byte is unmapped, including AA, FA, EE, FE, 00 and FF.
- Typematic repeats (the same make code arriving repeatedly without a break) each emit a character.
- Buffer is a circular FIFO with read and write pointers plus an occupancy count sized to `FIFO_DEPTH` (count reaches `FIFO_DEPTH`).
  - `char_data` always equals the entry at the read pointer.
  - Push when full: the character is dropped and `overflow` pulses, unless a pop occurs in the same cycle, in which case the push is accepted.
  - Push and pop in the same cycle when non-empty: count is unchanged and both pointers advance.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset while mid-sequence (for example after F0) returns the FSM to IDLE and empties the buffer. Any pending byte is lost.

## Timing
- Reset values: `char_valid`=0, `char_data`=0x00, `overflow`=0, FSM=IDLE, pointers and count=0.
- Strobe with a mapped make code in cycle N → `char_valid`=1 with the character in cycle N+1 (empty buffer).
- Pop takes effect at the edge where `char_valid && char_ready`. The next entry (or `char_valid`=0) appears in the following cycle.
- `char_data` must be held stable while `char_valid && !char_ready`.
- `overflow` is registered and asserts in cycle N+1 for the dropped push.
- `char_ready` while `char_valid`=0 has no effect.
- Back-to-back strobes on consecutive cycles are fully supported.

## Configuration
- `PS2_FIFO_EN` defined: buffer is a `FIFO_DEPTH`-entry FIFO as described above.
- `PS2_FIFO_EN` undefined: buffer is a single holding register (depth 1) and `FIFO_DEPTH` is ignored.
  - Push and pop in the same cycle are accepted, so the register reloads.
  - Push while the register is full without a pop is dropped with an `overflow` pulse.
  - Latency and handshake are unchanged.

## Test plan
- Reset, then strobe 1C with `char_ready`=1 → `char_valid` high one cycle later with `char_data`=0x41, and popped the next edge.
- Sequence 24, F0, 24 → exactly one 0x45. Sequence E0, 5A, E0, F0, 5A → no output. Sequence 5A → 0x0D.
- Hold `char_ready`=0 and send 1C, 32, 21, 23, 24 with the FIFO enabled → four entries A, B, C, D; `overflow` pulses once for E. Release ready → A, B, C, D drained in order, then `char_valid`=0.
- With the buffer full, strobe 45 in the same cycle as a pop → no overflow; 0x30 ends up at the tail; pointers wrap correctly.
- Send F0, then assert `rst`=0 for 2 cycles, release, then send 16 → 0x31 emitted (break state cleared). Send AA and FA → no output.
- With `PS2_FIFO_EN` undefined and ready=0, send 1C, 32 → only 0x41 held and `overflow` pulses for B. With ready=1, send back-to-back 1C, 32 → 0x41 then 0x42.
